// File: rtl/ve_softmax_stat_seq.sv
// Two-pass softmax statistics sequencer: buffers tile partials, tracks the row max, then replays
// tiles into the exp-product merge stage and issues the final ln request. Optional: VE_SEQ_TIMEOUT_EN.
module ve_softmax_stat_seq #(
   parameter int unsigned ELTNUM = 4,
   parameter int unsigned ELTBIT = 16,
   parameter int unsigned DEPTH  = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     inValid,
   output logic                     inReady,
   input  logic                     inLast,
   input  logic [ELTNUM*ELTBIT-1:0] inPartMax,
   input  logic [ELTNUM*ELTBIT-1:0] inPartSum,
   output logic                     epValid,
   output logic                     epLast,
   output logic [ELTNUM*ELTBIT-1:0] epPartMax,
   output logic [ELTNUM*ELTBIT-1:0] epPartSum,
   output logic [ELTBIT-1:0]        epAllMax,
   output logic [ELTBIT-1:0]        epAllSum,
   input  logic                     epRetValid,
   input  logic [ELTBIT-1:0]        epRetSum,
   output logic                     outValid,
   input  logic                     outReady,
   output logic [ELTBIT-1:0]        outMax,
   output logic [ELTBIT-1:0]        outLnSum,
   output logic                     ovf,
   output logic                     tmoErr
);

   localparam int unsigned VECW = ELTNUM * ELTBIT;
   localparam int unsigned IDXW = $clog2(DEPTH);
   localparam int unsigned CNTW = IDXW + 1;
   localparam logic [ELTBIT-1:0] NEG_INF = ELTBIT'(16'hFC00);

   localparam logic [2:0] COLLECT = 3'd0;
   localparam logic [2:0] ISSUE   = 3'd1;
   localparam logic [2:0] WAIT    = 3'd2;
   localparam logic [2:0] LNISSUE = 3'd3;
   localparam logic [2:0] LNWAIT  = 3'd4;
   localparam logic [2:0] DONE    = 3'd5;

   logic [2:0]        state_q, state_d;
   logic [CNTW-1:0]   cnt_q, cnt_d, rd_q, rd_d;
   logic [ELTBIT-1:0] run_max_q, run_max_d, run_sum_q, run_sum_d;
   logic              ep_valid_q, ep_valid_d, ep_last_q, ep_last_d;
   logic [VECW-1:0]   ep_part_max_q, ep_part_max_d, ep_part_sum_q, ep_part_sum_d;
   logic [ELTBIT-1:0] ep_all_max_q, ep_all_max_d, ep_all_sum_q, ep_all_sum_d;
   logic              out_valid_q, out_valid_d;
   logic [ELTBIT-1:0] out_max_q, out_max_d, out_ln_sum_q, out_ln_sum_d;
   logic              ovf_q, ovf_d;
   logic [VECW-1:0]   buf_max_q [DEPTH];
   logic [VECW-1:0]   buf_sum_q [DEPTH];
   logic              buf_we;
   logic [ELTBIT-1:0] tile_max;
`ifdef VE_SEQ_TIMEOUT_EN
   logic              tmo_err_q, tmo_err_d;
   logic [5:0]        tmo_cnt_q, tmo_cnt_d;
`endif

   // fp16 max by sign/magnitude ordering; +0 beats -0, NaN not handled
   function automatic logic [ELTBIT-1:0] fp_max(input logic [ELTBIT-1:0] a, input logic [ELTBIT-1:0] b);
      if (a[ELTBIT-1] != b[ELTBIT-1]) return a[ELTBIT-1] ? b : a;
      else if (!a[ELTBIT-1])         return (a > b) ? a : b;
      else                           return (a < b) ? a : b;
   endfunction

   always_comb begin
      tile_max = run_max_q;
      for (int unsigned i = 0; i < ELTNUM; i++)
         tile_max = fp_max(tile_max, inPartMax[i*ELTBIT +: ELTBIT]);
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      rd_d          = rd_q;
      run_max_d     = run_max_q;
      run_sum_d     = run_sum_q;
      ep_valid_d    = 1'b0;
      ep_last_d     = ep_last_q;
      ep_part_max_d = ep_part_max_q;
      ep_part_sum_d = ep_part_sum_q;
      ep_all_max_d  = ep_all_max_q;
      ep_all_sum_d  = ep_all_sum_q;
      out_max_d     = out_max_q;
      out_ln_sum_d  = out_ln_sum_q;
      ovf_d         = ovf_q;
      buf_we        = 1'b0;
`ifdef VE_SEQ_TIMEOUT_EN
      tmo_err_d     = tmo_err_q;
      tmo_cnt_d     = '0;
`endif
      case (state_q)
         COLLECT: begin
            if (inValid) begin
               buf_we    = 1'b1;
               cnt_d     = cnt_q + CNTW'(1);
               run_max_d = tile_max;
               // a full buffer closes the row even without inLast
               if (inLast || (cnt_q + CNTW'(1)) == CNTW'(DEPTH)) begin
                  state_d = ISSUE;
                  rd_d    = '0;
                  if (!inLast) ovf_d = 1'b1;
               end
            end
         end
         ISSUE: begin
            ep_valid_d    = 1'b1;
            ep_last_d     = 1'b0;
            ep_part_max_d = buf_max_q[rd_q[IDXW-1:0]];
            ep_part_sum_d = buf_sum_q[rd_q[IDXW-1:0]];
            ep_all_max_d  = run_max_q;
            ep_all_sum_d  = run_sum_q;
            state_d       = WAIT;
         end
         WAIT: begin
            if (epRetValid) begin
               run_sum_d = epRetSum;
               rd_d      = rd_q + CNTW'(1);
               state_d   = ((rd_q + CNTW'(1)) == cnt_q) ? LNISSUE : ISSUE;
            end
         end
         LNISSUE: begin
            ep_valid_d    = 1'b1;
            ep_last_d     = 1'b1;
            ep_part_max_d = '0;
            ep_part_sum_d = '0;
            ep_all_max_d  = run_max_q;
            ep_all_sum_d  = run_sum_q;
            state_d       = LNWAIT;
         end
         LNWAIT: begin
            if (epRetValid) begin
               out_ln_sum_d = epRetSum;
               out_max_d    = run_max_q;
               state_d      = DONE;
            end
         end
         DONE: begin
            if (outReady) begin
               state_d   = COLLECT;
               cnt_d     = '0;
               rd_d      = '0;
               run_sum_d = '0;
               run_max_d = NEG_INF;
            end
         end
         default: state_d = COLLECT;
      endcase
`ifdef VE_SEQ_TIMEOUT_EN
      // give up on a silent merge stage and flag the result as NaN
      if ((state_q == WAIT || state_q == LNWAIT) && !epRetValid && tmo_cnt_q == 6'd63) begin
         tmo_err_d    = 1'b1;
         out_ln_sum_d = ELTBIT'(16'h7E00);
         out_max_d    = run_max_q;
         state_d      = DONE;
      end
      if (state_d == state_q && (state_q == WAIT || state_q == LNWAIT))
         tmo_cnt_d = tmo_cnt_q + 6'd1;
`endif
      out_valid_d = (state_d == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= COLLECT;
         cnt_q         <= '0;
         rd_q          <= '0;
         run_max_q     <= NEG_INF;
         run_sum_q     <= '0;
         ep_valid_q    <= 1'b0;
         ep_last_q     <= 1'b0;
         ep_part_max_q <= '0;
         ep_part_sum_q <= '0;
         ep_all_max_q  <= '0;
         ep_all_sum_q  <= '0;
         out_valid_q   <= 1'b0;
         out_max_q     <= '0;
         out_ln_sum_q  <= '0;
         ovf_q         <= 1'b0;
`ifdef VE_SEQ_TIMEOUT_EN
         tmo_err_q     <= 1'b0;
         tmo_cnt_q     <= '0;
`endif
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         rd_q          <= rd_d;
         run_max_q     <= run_max_d;
         run_sum_q     <= run_sum_d;
         ep_valid_q    <= ep_valid_d;
         ep_last_q     <= ep_last_d;
         ep_part_max_q <= ep_part_max_d;
         ep_part_sum_q <= ep_part_sum_d;
         ep_all_max_q  <= ep_all_max_d;
         ep_all_sum_q  <= ep_all_sum_d;
         out_valid_q   <= out_valid_d;
         out_max_q     <= out_max_d;
         out_ln_sum_q  <= out_ln_sum_d;
         ovf_q         <= ovf_d;
`ifdef VE_SEQ_TIMEOUT_EN
         tmo_err_q     <= tmo_err_d;
         tmo_cnt_q     <= tmo_cnt_d;
`endif
      end
   end

   // tile buffer holds no reset; contents are don't-care after an abort
   always_ff @(posedge clk) begin
      if (buf_we) begin
         buf_max_q[cnt_q[IDXW-1:0]] <= inPartMax;
         buf_sum_q[cnt_q[IDXW-1:0]] <= inPartSum;
      end
   end

   assign inReady   = (state_q == COLLECT) && !rst;
   assign epValid   = ep_valid_q;
   assign epLast    = ep_last_q;
   assign epPartMax = ep_part_max_q;
   assign epPartSum = ep_part_sum_q;
   assign epAllMax  = ep_all_max_q;
   assign epAllSum  = ep_all_sum_q;
   assign outValid  = out_valid_q;
   assign outMax    = out_max_q;
   assign outLnSum  = out_ln_sum_q;
   assign ovf       = ovf_q;
`ifdef VE_SEQ_TIMEOUT_EN
   assign tmoErr    = tmo_err_q;
`else
   assign tmoErr    = 1'b0;
`endif

endmodule

// File: tb/tb_ve_softmax_stat_seq.sv
// Directed bench for ve_softmax_stat_seq with a fixed-latency merge-stage stub returning 0x3C00*k.
module tb_ve_softmax_stat_seq;

   localparam int L = 9;

   logic        clk = 1'b0;
   logic        rst;
   logic        inValid, inReady, inLast;
   logic [63:0] inPartMax, inPartSum;
   logic        epValid, epLast;
   logic [63:0] epPartMax, epPartSum;
   logic [15:0] epAllMax, epAllSum;
   logic        epRetValid;
   logic [15:0] epRetSum;
   logic        outValid, outReady;
   logic [15:0] outMax, outLnSum;
   logic        ovf, tmoErr;

   ve_softmax_stat_seq dut (
      .clk(clk), .rst(rst),
      .inValid(inValid), .inReady(inReady), .inLast(inLast),
      .inPartMax(inPartMax), .inPartSum(inPartSum),
      .epValid(epValid), .epLast(epLast),
      .epPartMax(epPartMax), .epPartSum(epPartSum),
      .epAllMax(epAllMax), .epAllSum(epAllSum),
      .epRetValid(epRetValid), .epRetSum(epRetSum),
      .outValid(outValid), .outReady(outReady),
      .outMax(outMax), .outLnSum(outLnSum),
      .ovf(ovf), .tmoErr(tmoErr)
   );

   always #5 clk = ~clk;

   int          n_err = 0, n_chk = 0;
   int          cyc = 0, req_n = 0, req_cyc = 0, stub_cd = -1;
   bit          stub_en = 1'b1;
   logic [15:0] stub_val;
   logic [63:0] lg_pmax [16];
   logic [63:0] lg_psum [16];
   logic [15:0] lg_amax [16];
   logic [15:0] lg_asum [16];
   logic        lg_last [16];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] vec(input logic [15:0] l0, input logic [15:0] l1,
                                       input logic [15:0] l2, input logic [15:0] l3);
      return {l3, l2, l1, l0};
   endfunction

   // one clock; then the merge stub: log requests, return L cycles after epValid
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      epRetValid = 1'b0;
      if (stub_cd > 0) begin
         stub_cd--;
         if (stub_cd == 0) begin
            epRetValid = 1'b1;
            epRetSum   = stub_val;
            stub_cd    = -1;
         end
      end
      if (epValid) begin
         if (req_n < 16) begin
            lg_pmax[req_n] = epPartMax;
            lg_psum[req_n] = epPartSum;
            lg_amax[req_n] = epAllMax;
            lg_asum[req_n] = epAllSum;
            lg_last[req_n] = epLast;
         end
         req_cyc = cyc;
         if (stub_en) begin
            stub_cd  = L;
            stub_val = 16'(32'h3C00 * (req_n + 1));
         end
         req_n++;
      end
   endtask

   task automatic send(input logic [63:0] mx, input logic lst);
      inValid   = 1'b1;
      inPartMax = mx;
      inPartSum = ~mx;
      inLast    = lst;
      tick();
      inValid = 1'b0;
      inLast  = 1'b0;
   endtask

   task automatic wait_out(output int n);
      n = 0;
      while (!outValid && n < 400) begin
         tick();
         n++;
      end
   endtask

   task automatic finish_row();
      outReady = 1'b1;
      tick();
      outReady = 1'b0;
   endtask

   int n;

   initial begin
      rst = 1'b1; inValid = 1'b0; inLast = 1'b0; inPartMax = '0; inPartSum = '0;
      epRetValid = 1'b0; epRetSum = '0; outReady = 1'b0;
      tick(); tick();
      check("rst_inready", 64'(inReady), 64'd0);
      check("rst_epvalid", 64'(epValid), 64'd0);
      check("rst_outvalid", 64'(outValid), 64'd0);
      check("rst_outmax", 64'(outMax), 64'd0);
      check("rst_ovf", 64'(ovf), 64'd0);
      check("rst_tmo", 64'(tmoErr), 64'd0);
      rst = 1'b0;
      tick();
      check("rel_inready", 64'(inReady), 64'd1);

      // single tile
      req_n = 0;
      send(vec(16'h3C00, 16'h4000, 16'hBC00, 16'h0000), 1'b1);
      wait_out(n);
      check("t1_lat", 64'(n + 1), 64'(1 + 2 * (L + 2)));
      check("t1_nreq", 64'(req_n), 64'd2);
      check("t1_amax", 64'(lg_amax[0]), 64'h4000);
      check("t1_asum", 64'(lg_asum[0]), 64'h0000);
      check("t1_last0", 64'(lg_last[0]), 64'd0);
      check("t1_pmax", lg_pmax[0], vec(16'h3C00, 16'h4000, 16'hBC00, 16'h0000));
      check("t1_last1", 64'(lg_last[1]), 64'd1);
      check("t1_ln_pmax", lg_pmax[1], 64'd0);
      check("t1_ln_psum", lg_psum[1], 64'd0);
      check("t1_ln_asum", 64'(lg_asum[1]), 64'h3C00);
      check("t1_outmax", 64'(outMax), 64'h4000);
      check("t1_outln", 64'(outLnSum), 64'h7800);
      // stray return in DONE, then hold without outReady
      epRetValid = 1'b1; epRetSum = 16'h1234;
      tick();
      repeat (4) tick();
      check("hold_valid", 64'(outValid), 64'd1);
      check("hold_max", 64'(outMax), 64'h4000);
      check("hold_ln", 64'(outLnSum), 64'h7800);
      check("hold_inready", 64'(inReady), 64'd0);
      finish_row();
      check("hs_outvalid", 64'(outValid), 64'd0);
      check("hs_inready", 64'(inReady), 64'd1);
      epRetValid = 1'b1; epRetSum = 16'h5555;
      tick();

      // four tiles, row max 4800
      req_n = 0;
      send(vec(16'h4400, 16'h0000, 16'h3C00, 16'hBC00), 1'b0);
      send(vec(16'hC000, 16'hC400, 16'hC200, 16'hC800), 1'b0);
      send(vec(16'h4800, 16'h4400, 16'h0000, 16'h0000), 1'b0);
      send(vec(16'h3C00, 16'h3800, 16'h8000, 16'hBC00), 1'b1);
      check("t2_inready", 64'(inReady), 64'd0);
      wait_out(n);
      check("t2_lat", 64'(n + 1), 64'(1 + 5 * (L + 2)));
      check("t2_nreq", 64'(req_n), 64'd5);
      for (int i = 0; i < 4; i++) check($sformatf("t2_amax%0d", i), 64'(lg_amax[i]), 64'h4800);
      check("t2_asum0", 64'(lg_asum[0]), 64'h0000);
      check("t2_asum1", 64'(lg_asum[1]), 64'h3C00);
      check("t2_asum2", 64'(lg_asum[2]), 64'h7800);
      check("t2_asum3", 64'(lg_asum[3]), 64'hB400);
      check("t2_ln_asum", 64'(lg_asum[4]), 64'hF000);
      check("t2_pmax2", lg_pmax[2], vec(16'h4800, 16'h4400, 16'h0000, 16'h0000));
      check("t2_outmax", 64'(outMax), 64'h4800);
      check("t2_outln", 64'(outLnSum), 64'h2C00);
      check("t2_ovf", 64'(ovf), 64'd0);
      finish_row();

      // negative-only and signed-zero lanes
      req_n = 0;
      send(vec(16'hC000, 16'hBC00, 16'hC400, 16'hC200), 1'b1);
      wait_out(n);
      check("t3_neg_max", 64'(outMax), 64'hBC00);
      finish_row();
      req_n = 0;
      send(vec(16'h8000, 16'h0000, 16'h8000, 16'hBC00), 1'b1);
      wait_out(n);
      check("t3_zero_max", 64'(outMax[14:0]), 64'd0);
      finish_row();

      // eight tiles without inLast overflow the buffer
      req_n = 0;
      for (int i = 0; i < 8; i++) send(vec(16'(16'h3C00 + i * 16'h0100), 16'h0, 16'h0, 16'h0), 1'b0);
      check("t4_ovf", 64'(ovf), 64'd1);
      check("t4_inready", 64'(inReady), 64'd0);
      wait_out(n);
      check("t4_lat", 64'(n + 1), 64'(1 + 9 * (L + 2)));
      check("t4_nreq", 64'(req_n), 64'd9);
      check("t4_last7", 64'(lg_last[7]), 64'd0);
      check("t4_last8", 64'(lg_last[8]), 64'd1);
      check("t4_ln_asum", 64'(lg_asum[8]), 64'hE000);
      check("t4_outmax", 64'(outMax), 64'h4300);
      finish_row();

      // reset while waiting on the merge stage
      stub_en = 1'b0;
      req_n = 0;
      send(vec(16'h4000, 16'h0, 16'h0, 16'h0), 1'b1);
      repeat (20) tick();
      check("t5_wait_outvalid", 64'(outValid), 64'd0);
      check("t5_wait_inready", 64'(inReady), 64'd0);
      check("t5_wait_nreq", 64'(req_n), 64'd1);
      rst = 1'b1;
      tick();
      check("t5_rst_epvalid", 64'(epValid), 64'd0);
      check("t5_rst_amax", 64'(epAllMax), 64'd0);
      check("t5_rst_outmax", 64'(outMax), 64'd0);
      check("t5_rst_ovf", 64'(ovf), 64'd0);
      rst = 1'b0;
      tick();
      check("t5_rel_inready", 64'(inReady), 64'd1);

      // merge stage never answers
      req_n = 0;
      send(vec(16'h4400, 16'h0, 16'h0, 16'h0), 1'b1);
`ifdef VE_SEQ_TIMEOUT_EN
      n = 0;
      while (!tmoErr && n < 200) begin
         tick();
         n++;
      end
      check("t6_tmo", 64'(tmoErr), 64'd1);
      check("t6_tmo_lat", 64'(cyc - req_cyc), 64'd64);
      check("t6_outln", 64'(outLnSum), 64'h7E00);
      check("t6_outmax", 64'(outMax), 64'h4400);
      check("t6_outvalid", 64'(outValid), 64'd1);
`else
      repeat (100) tick();
      check("t6_outvalid", 64'(outValid), 64'd0);
      check("t6_tmo", 64'(tmoErr), 64'd0);
      check("t6_nreq", 64'(req_n), 64'd1);
      check("t6_inready", 64'(inReady), 64'd0);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/ve_softmax_stat_seq.md
# ve_softmax_stat_seq

Two-pass sequencer that produces the global softmax statistics (row max and log-sum-exp) for one row split into tiles. It sits directly upstream of the exp-product merge stage. In pass 1 it buffers per-tile partial max/sum vectors and tracks the running row max. In pass 2 it replays each tile into the merge stage against that max, chains the returned partial sum back in, and finally issues the ln request and presents the result.

## Interface
- ELTNUM, 4, elements per tile vector (power of two, ≥2)
- ELTBIT, 16, element width; fp16 (1/5/10) encoding
- DEPTH, 8, max tiles per row (power of two, ≥2)

- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous and active-high
- inValid  in  1  tile offered
- inReady  out  1  tile accepted when inValid&inReady
- inLast  in  1  offered tile is last of row
- inPartMax  in  ELTNUM*ELTBIT  per-lane partial max
- inPartSum  in  ELTNUM*ELTBIT  per-lane partial exp-sum
- epValid  out  1  one-cycle request pulse to merge stage
- epLast  out  1  request is the ln request
- epPartMax  out  ELTNUM*ELTBIT  replayed partial max (0 on ln request)
- epPartSum  out  ELTNUM*ELTBIT  replayed partial sum (0 on ln request)
- epAllMax  out  ELTBIT  row max
- epAllSum  out  ELTBIT  running sum fed in
- epRetValid  in  1  merge stage result valid
- epRetSum  in  ELTBIT  merge stage result (sum, or ln on ln request)
- outValid  out  1  result available
- outReady  in  1  result consumed when outValid&outReady
- outMax  out  ELTBIT  row max
- outLnSum  out  ELTBIT  ln of row exp-sum
- ovf  out  1  sticky: DEPTH tiles seen without inLast
- tmoErr  out  1  sticky: return timeout (see Configuration)

## Operation
- States: COLLECT, ISSUE, WAIT, LNISSUE, LNWAIT, DONE. Reset state is COLLECT.
- COLLECT
  - inReady = 1 (combinational from state).
  - Accepted tile is written to buffer[cnt]; cnt increments.
  - runMax <= fpmax(runMax, all ELTNUM lanes of inPartMax). runMax initialises to -inf (16'hFC00).
  - Leave to ISSUE with rd = 0 when the accepted tile has inLast=1, or when cnt reaches DEPTH. In the DEPTH case, set ovf and treat that tile as last.
- fpmax ordering
  - Opposite signs: the positive value wins.
  - Both positive: the larger bit pattern wins.
  - Both negative: the smaller bit pattern wins.
  - +0 and -0 are equal; either may be returned.
  - NaN inputs are unsupported.
- ISSUE
  - epValid=1 for exactly one cycle.
  - ep* carries buffer[rd], epAllMax=runMax, epAllSum=runSum, epLast=0.
  - Next state is WAIT.
- WAIT
  - On epRetValid: runSum <= epRetSum and rd increments.
  - Next state is LNISSUE if rd+1 == cnt, else ISSUE.
- LNISSUE
  - epValid=1, epLast=1, part vectors 0, epAllSum=runSum, epAllMax=runMax.
  - Next state is LNWAIT.
- LNWAIT
  - On epRetValid: outLnSum <= epRetSum, outMax <= runMax, then go to DONE.
- DONE
  - outValid=1; outMax/outLnSum held stable.
  - On outReady: go to COLLECT and clear cnt, rd, runSum (to 0) and runMax (to -inf). ovf and tmoErr are not cleared.
- epRetValid outside WAIT/LNWAIT is ignored.
- Exactly one request is in flight at a time.
- ep* outputs are registered. epValid is 0 outside ISSUE/LNISSUE cycles; part vectors, epAllMax and epAllSum hold their last values.
- Reset (any cycle, including mid-row) aborts the row; buffer contents are don't-care.
- Output reset values: all outputs 0, with inReady=1 from the first cycle after reset release.

## Timing
- Collect: one tile per cycle.
- ISSUE to merge stage: epValid asserts the cycle after entering ISSUE state (registered output).
- Round trip per tile: 1 issue cycle + L cycles of merge latency + 1 capture cycle.
- Row latency from the last accepted tile to outValid: 1 + (N+1)·(L+2) cycles for N tiles, with no backpressure.
- outValid rises the cycle after the ln capture and holds until outReady.
- inReady=0 from the cycle after the last tile until the cycle after the DONE handshake.

## Configuration
- VE_SEQ_TIMEOUT_EN
  - Defined: a 6-bit counter runs in WAIT/LNWAIT and clears on state entry.
  - If 63 cycles pass without epRetValid: set tmoErr, load outLnSum with 16'h7E00 (NaN) and outMax with runMax, and go to DONE.
  - Not defined: no counter; the block waits indefinitely and tmoErr is tied 0.

## Test plan
- Single tile, lanes {3C00,4000,BC00,0000}, inLast=1; stub returns with L=9 → epAllMax=4000, epAllSum=0000 on the tile request, one ln request with epLast=1, outMax=4000, outLnSum = stub value.
- Four tiles with maxima 4400/C000/4800/3C00 and a stub returning 0x3C00·k → epAllMax=4800 on all 4 requests, epAllSum sequence 0,3C00,stub2,stub3, outValid 1+5·11 cycles after the last tile.
- Negative-only lanes {C000,BC00,C400,C200} → outMax=BC00; mixed ±0 lanes → result is ±0.
- DEPTH=8 tiles, none with inLast → ovf=1, inReady=0 after the 8th tile, 8 tile requests plus 1 ln request.
- outReady held 0 for 5 cycles in DONE → outputs stable; a stray epRetValid during COLLECT/DONE has no effect; reset asserted in WAIT → outputs 0, state COLLECT.
- With VE_SEQ_TIMEOUT_EN, stub never returns → tmoErr=1 and outLnSum=7E00 64 cycles after the request; without the macro the block stays in WAIT.
